pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_pkg.sv | 12 +
 rtl/pc_next_adder.sv | 17 +
 rtl/pc_fetch_ctrl.sv | 73 +++++++
 tb/tb_pc_fetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package pc_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetchState_e;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;
  localparam logic [31:0] PC_INCR      = 32'd4;

endpackage

// File: rtl/pc_next_adder.sv
// Combinational next-PC: sequential PC+4, or PC+4 plus a word-scaled branch offset.
module pc_next_adder
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] immedPc_i,
  input  logic        pcSel_i,
  output logic [31:0] nextPc_o
);

  logic [31:0] seqPc;

  // The shift drops immedPc_i[31:30]; everything wraps modulo 2^32.
  assign seqPc    = pc_i + PC_INCR;
  assign nextPc_o = pcSel_i ? (seqPc + (immedPc_i << 2)) : seqPc;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Two-state fetch controller: requests a word at PC, holds it until decode consumes it.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pcLdEn_i,
  input  logic        pcSel_i,
  input  logic [31:0] immedPc_i,
  input  logic        imemAck_i,
  input  logic [31:0] imemData_i,
  input  logic        instrReady_i,
  output logic        imemReq_o,
  output logic [31:0] imemAddr_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        instrValid_o
);

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] nextPc;

  pc_next_adder u_pcNextAdder (
    .pc_i      (pc_q),
    .immedPc_i (immedPc_i),
    .pcSel_i   (pcSel_i),
    .nextPc_o  (nextPc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET_VAL;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Request is gated by reset so nothing reaches memory while reset is held.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    imemReq_o    = 1'b0;
    instrValid_o = 1'b0;
    unique case (state_q)
      FETCH: begin
        imemReq_o = ~rst_i;
        if (imemAck_i) begin
          instr_d = imemData_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instrValid_o = 1'b1;
        if (instrReady_i) begin
          state_d = FETCH;
          if (pcLdEn_i) pc_d = nextPc;
        end
      end
    endcase
  end

  assign imemAddr_o = pc_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl against a transaction-level PC model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcLdEn, pcSel, imemAck, instrReady;
  logic [31:0] immedPc, imemData;
  logic        imemReq, instrValid;
  logic [31:0] imemAddr, pc, instr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetchTxn_t;

  typedef enum {PH_IDLE, PH_RESET, PH_FETCH, PH_HOLD} tbPhase_e;

  fetchTxn_t   expQ[$];
  tbPhase_e    phase = PH_IDLE;
  logic [31:0] modelPc;
  int          checks = 0;
  int          errors = 0;

  pc_fetch_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pcLdEn_i     (pcLdEn),
    .pcSel_i      (pcSel),
    .immedPc_i    (immedPc),
    .imemAck_i    (imemAck),
    .imemData_i   (imemData),
    .instrReady_i (instrReady),
    .imemReq_o    (imemReq),
    .imemAddr_o   (imemAddr),
    .pc_o         (pc),
    .instr_o      (instr),
    .instrValid_o (instrValid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomizeIdleInputs();
    pcLdEn   = 1'($urandom_range(0, 1));
    pcSel    = 1'($urandom_range(0, 1));
    immedPc  = $urandom;
    imemData = $urandom;
  endtask

  // Monitor: checks DUT outputs mid-cycle against the expected transaction at the queue head.
  always @(negedge clk) begin
    case (phase)
      PH_RESET: begin
        checkOutput("reset imemReq", 32'(imemReq), 32'd0);
        checkOutput("reset instrValid", 32'(instrValid), 32'd0);
        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset instr", instr, 32'h0);
      end
      PH_FETCH: begin
        if (expQ.size() == 0) begin
          checkOutput("fetch scoreboard underflow", 32'd0, 32'd1);
        end else begin
          checkOutput("fetch imemReq", 32'(imemReq), 32'd1);
          checkOutput("fetch instrValid", 32'(instrValid), 32'd0);
          checkOutput("fetch imemAddr", imemAddr, expQ[0].addr);
          checkOutput("fetch pc", pc, expQ[0].addr);
        end
      end
      PH_HOLD: begin
        if (expQ.size() == 0) begin
          checkOutput("hold scoreboard underflow", 32'd0, 32'd1);
        end else begin
          checkOutput("hold imemReq", 32'(imemReq), 32'd0);
          checkOutput("hold instrValid", 32'(instrValid), 32'd1);
          checkOutput("hold instr", instr, expQ[0].data);
          checkOutput("hold pc", pc, expQ[0].addr);
          if (instrReady) void'(expQ.pop_front());
        end
      end
      default: ;
    endcase
  end

  task automatic applyReset(input int cycles);
    rst        = 1'b1;
    phase      = PH_RESET;
    imemAck    = 1'b0;
    instrReady = 1'b0;
    randomizeIdleInputs();
    expQ.delete();
    modelPc = 32'h0;
    repeat (cycles) nextCycle();
    rst = 1'b0;
  endtask

  // One instruction: fetch with waitCycles stalls, hold holdCycles, then consume.
  task automatic applyStimulus(input int waitCycles, input logic [31:0] data, input int holdCycles,
                               input logic ldEn, input logic sel, input logic [31:0] immed);
    fetchTxn_t t;
    t.addr = modelPc;
    t.data = data;
    expQ.push_back(t);
    phase = PH_FETCH;
    for (int i = 0; i < waitCycles; i++) begin
      imemAck    = 1'b0;
      instrReady = 1'($urandom_range(0, 1));
      randomizeIdleInputs();
      nextCycle();
    end
    imemAck    = 1'b1;
    instrReady = 1'($urandom_range(0, 1));
    randomizeIdleInputs();
    imemData   = data;
    nextCycle();
    phase = PH_HOLD;
    for (int i = 0; i < holdCycles; i++) begin
      imemAck    = 1'($urandom_range(0, 1));
      instrReady = 1'b0;
      randomizeIdleInputs();
      nextCycle();
    end
    imemAck    = 1'($urandom_range(0, 1));
    imemData   = $urandom;
    instrReady = 1'b1;
    pcLdEn     = ldEn;
    pcSel      = sel;
    immedPc    = immed;
    nextCycle();
    if (ldEn) modelPc = sel ? (modelPc + 32'd4 + immed * 32'd4) : (modelPc + 32'd4);
    instrReady = 1'b0;
  endtask

  task automatic branchTo(input logic [31:0] target);
    logic [31:0] offs;
    offs = (target - modelPc - 32'd4) >> 2;
    applyStimulus($urandom_range(0, 2), $urandom, $urandom_range(0, 2), 1'b1, 1'b1, offs);
  endtask

  // Reset lands on a cycle with imemAck high, either mid-fetch or while holding.
  task automatic resetMidTxn(input int waitCycles, input logic duringHold);
    fetchTxn_t t;
    t.addr = modelPc;
    t.data = $urandom;
    expQ.push_back(t);
    phase = PH_FETCH;
    for (int i = 0; i < waitCycles; i++) begin
      imemAck = 1'b0;
      randomizeIdleInputs();
      nextCycle();
    end
    if (duringHold) begin
      imemAck  = 1'b1;
      imemData = t.data;
      nextCycle();
      phase   = PH_HOLD;
      imemAck = 1'b0;
      nextCycle();
    end
    imemAck = 1'b1;
    rst     = 1'b1;
    phase   = PH_RESET;
    expQ.delete();
    modelPc = 32'h0;
    nextCycle();
    imemAck = 1'b0;
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    applyReset(3);
    applyStimulus(3, 32'h1234_5678, 0, 1'b1, 1'b0, 32'h0);
    branchTo(32'h0000_0100);
    applyStimulus(1, $urandom, 1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(0, $urandom, 0, 1'b1, 1'b0, 32'h0);
    applyStimulus(2, $urandom, 0, 1'b1, 1'b1, 32'h0000_0003);
    applyStimulus(0, $urandom, 5, 1'b1, 1'b0, 32'h0);
    applyStimulus(1, $urandom, 0, 1'b1, 1'b1, 32'hC000_0001);
    branchTo(32'hFFFF_FFFC);
    applyStimulus(0, $urandom, 0, 1'b1, 1'b0, 32'h0);
    applyStimulus(0, $urandom, 0, 1'b1, 1'b0, 32'h0);
    branchTo(32'h0000_0040);
    applyStimulus(1, $urandom, 1, 1'b0, 1'b1, $urandom);
    applyStimulus(0, $urandom, 0, 1'b1, 1'b0, 32'h0);
    resetMidTxn(2, 1'b0);
    applyStimulus(0, $urandom, 0, 1'b1, 1'b0, 32'h0);
    resetMidTxn(1, 1'b1);
    for (int n = 0; n < 300; n++) begin
      applyStimulus($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
    end
    phase = PH_IDLE;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
